alu_arbiter: RTL

Two-port arbiter and sequencer for the shared 16-bit ALU. It grants the ALU to one of two requesters (instruction path and auxiliary path) round-robin. It drives the ALU through its write-then-read sequence and returns the result and flags with a one-cycle acknowledge. Optionally it keeps per-requester flag contexts so carry chains from the two requesters do not corrupt each other.

---
 rtl/alu_arbiter_if.sv | 46 ++++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester and ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if;
  logic        req0;
  logic        req1;
  logic [3:0]  op0;
  logic [3:0]  op1;
  logic [15:0] a0;
  logic [15:0] b0;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        cin0;
  logic        cin1;
  logic        ack0;
  logic        ack1;
  logic [15:0] result;
  logic [2:0]  flags;
  logic        alu_we;
  logic        alu_oe;
  logic        alu_set_state;
  logic [2:0]  alu_new_state;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_cin;
  logic [15:0] alu_z;
  logic        alu_cout;
  logic        alu_zero;
  logic        alu_sign;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, cin0, cin1,
    input  alu_z, alu_cout, alu_zero, alu_sign,
    output ack0, ack1, result, flags,
    output alu_we, alu_oe, alu_set_state, alu_new_state,
    output alu_a, alu_b, alu_opcode, alu_cin
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, cin0, cin1,
    output alu_z, alu_cout, alu_zero, alu_sign,
    input  ack0, ack1, result, flags,
    input  alu_we, alu_oe, alu_set_state, alu_new_state,
    input  alu_a, alu_b, alu_opcode, alu_cin
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter/sequencer for the shared 16-bit ALU.
// Define ALU_ARB_FLAGSAVE_EN for per-requester flag shadows with a RESTORE state.
module alu_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESTORE = 2'd1,
    S_EXEC    = 2'd2,
    S_READ    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        ptr_q, ptr_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;
  logic        elig0, elig1;

`ifdef ALU_ARB_FLAGSAVE_EN
  logic        last_owner_q, last_owner_d;
  logic [2:0]  shadow0_q, shadow0_d;
  logic [2:0]  shadow1_q, shadow1_d;
`endif

  // A requester whose ack is still visible is not eligible, so it cannot be re-granted on stale req.
  assign elig0 = bus.req0 && !ack0_q;
  assign elig1 = bus.req1 && !ack1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      ptr_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      result_q     <= 16'h0000;
      flags_q      <= 3'b000;
`ifdef ALU_ARB_FLAGSAVE_EN
      last_owner_q <= 1'b0;
      shadow0_q    <= 3'b000;
      shadow1_q    <= 3'b000;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
`ifdef ALU_ARB_FLAGSAVE_EN
      last_owner_q <= last_owner_d;
      shadow0_q    <= shadow0_d;
      shadow1_q    <= shadow1_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (elig0 || elig1) begin
          grant_d = (elig0 && elig1) ? ptr_q : elig1;
          ptr_d   = ~grant_d;
`ifdef ALU_ARB_FLAGSAVE_EN
          state_d = (grant_d != last_owner_q) ? S_RESTORE : S_EXEC;
`else
          state_d = S_EXEC;
`endif
        end
      end
      S_RESTORE: state_d = S_EXEC;
      S_EXEC:    state_d = S_READ;
      S_READ:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Completion capture: everything below updates only on the closing edge of READ.
  always_comb begin
    ack0_d   = (state_q == S_READ) && !grant_q;
    ack1_d   = (state_q == S_READ) &&  grant_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (state_q == S_READ) begin
      result_d = bus.alu_z;
      flags_d  = {bus.alu_cout, bus.alu_zero, bus.alu_sign};
    end
`ifdef ALU_ARB_FLAGSAVE_EN
    last_owner_d = last_owner_q;
    shadow0_d    = shadow0_q;
    shadow1_d    = shadow1_q;
    if (state_q == S_READ) begin
      last_owner_d = grant_q;
      if (grant_q) shadow1_d = {bus.alu_cout, bus.alu_zero, bus.alu_sign};
      else         shadow0_d = {bus.alu_cout, bus.alu_zero, bus.alu_sign};
    end
`endif
  end

  always_comb begin
    bus.alu_we     = (state_q == S_EXEC);
    bus.alu_oe     = (state_q == S_READ);
    bus.alu_a      = grant_q ? bus.a1   : bus.a0;
    bus.alu_b      = grant_q ? bus.b1   : bus.b0;
    bus.alu_opcode = grant_q ? bus.op1  : bus.op0;
    bus.alu_cin    = grant_q ? bus.cin1 : bus.cin0;
`ifdef ALU_ARB_FLAGSAVE_EN
    bus.alu_set_state = (state_q == S_RESTORE);
    bus.alu_new_state = (state_q == S_RESTORE) ? (grant_q ? shadow1_q : shadow0_q) : 3'b000;
`else
    bus.alu_set_state = 1'b0;
    bus.alu_new_state = 3'b000;
`endif
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule
